// File: rtl/apu_gain_ramp_ctrl_pkg.sv
// Shared definitions for the APU gain ramp sequencer.
//   GAIN_W    : width of the gain factor (unsigned, 5 fractional bits)
//   ODB_GAIN  : gain value representing 0 dB
//   state_e   : sequencer state encoding
//   amp_lut() : 32-entry amplifier level table, level index -> gain factor
package apu_gain_ramp_ctrl_pkg;

  localparam int unsigned GAIN_W   = 9;
  localparam int unsigned ODB_GAIN = 32;
  localparam int unsigned GAIN_MAX = 127;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SLEW     = 3'd1,
    ST_FADE_OUT = 3'd2,
    ST_HOLD     = 3'd3,
    ST_APPLY    = 3'd4
  } state_e;

  function automatic logic [GAIN_W-1:0] amp_lut(input logic [4:0] lvl);
    logic [GAIN_W-1:0] g;
    case (lvl)
      5'd0:  g = 9'd1;    5'd1:  g = 9'd2;    5'd2:  g = 9'd3;    5'd3:  g = 9'd4;
      5'd4:  g = 9'd5;    5'd5:  g = 9'd6;    5'd6:  g = 9'd7;    5'd7:  g = 9'd8;
      5'd8:  g = 9'd9;    5'd9:  g = 9'd10;   5'd10: g = 9'd11;   5'd11: g = 9'd13;
      5'd12: g = 9'd14;   5'd13: g = 9'd16;   5'd14: g = 9'd18;   5'd15: g = 9'd20;
      5'd16: g = 9'd23;   5'd17: g = 9'd25;   5'd18: g = 9'd29;   5'd19: g = 9'd32;
      5'd20: g = 9'd36;   5'd21: g = 9'd40;   5'd22: g = 9'd45;   5'd23: g = 9'd51;
      5'd24: g = 9'd57;   5'd25: g = 9'd64;   5'd26: g = 9'd72;   5'd27: g = 9'd80;
      5'd28: g = 9'd90;   5'd29: g = 9'd101;  5'd30: g = 9'd114;  default: g = 9'd127;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/apu_gain_ramp_ctrl.sv
// Click-free gain/routing sequencer for the APU amplifier stage.
// Level and mute changes slew the gain one STEP per sample tick; swap and
// bypass changes fade to silence, hold, switch routing, then fade back in.
// Ports:
//   MCLK_i, nRst_int_w        : audio master clock, async active-low reset
//   sample_tick_i             : one-cycle strobe per output sample pair
//   level_i, mute_i,
//   swap_lr_i, filter_bypass_i: requested (synchronized) configuration
//   gain_o                    : applied gain factor, 32 = 0 dB
//   swap_lr_o, filter_bypass_o: applied routing
//   mute_o                    : applied mute and gain has reached 0
//   busy_o                    : sequencer not idle
module apu_gain_ramp_ctrl
  import apu_gain_ramp_ctrl_pkg::*;
#(
  parameter int unsigned STEP           = 1,
  parameter int unsigned HOLD_SAMPLES   = 48,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              MCLK_i,
  input  logic              nRst_int_w,
  input  logic              sample_tick_i,
  input  logic [4:0]        level_i,
  input  logic              mute_i,
  input  logic              swap_lr_i,
  input  logic              filter_bypass_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic              swap_lr_o,
  output logic              filter_bypass_o,
  output logic              mute_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [7:0]        hold_q, hold_d;
  logic [15:0]       wdog_q, wdog_d;
  logic              mute_app_q, mute_app_d;
  logic              swap_q, swap_d;
  logic              byp_q, byp_d;

  // Watchdog keeps the ramp moving when the sample strobe is absent.
  logic wdog_exp, tick;
  assign wdog_exp = (wdog_q == 16'(TIMEOUT_CYCLES - 1));
  assign tick     = sample_tick_i | wdog_exp;
  assign wdog_d   = tick ? '0 : wdog_q + 16'd1;

  logic [GAIN_W-1:0] tgt;
  logic              struct_chg;
  assign tgt        = mute_app_q ? '0 : amp_lut(level_i);
  assign struct_chg = (swap_lr_i != swap_q) | (filter_bypass_i != byp_q);

  // 10-bit step arithmetic: clamp at target, never below 0 or above max.
  logic [9:0] g10, t10, s10, up10, toward10, fade10;
  logic [GAIN_W-1:0] toward, fade;
  always_comb begin
    g10  = {1'b0, gain_q};
    t10  = {1'b0, tgt};
    s10  = 10'(STEP);
    up10 = g10 + s10;
    if (g10 < t10)
      toward10 = (up10 >= t10) ? t10 : up10;
    else
      toward10 = (g10 >= t10 + s10) ? g10 - s10 : t10;
    fade10 = (g10 >= s10) ? g10 - s10 : '0;
    toward = (toward10 > 10'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : toward10[GAIN_W-1:0];
    fade   = (fade10   > 10'(GAIN_MAX)) ? GAIN_W'(GAIN_MAX) : fade10[GAIN_W-1:0];
  end

  // Transition cycles never step the gain; a tick landing on one is dropped.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_q;
    hold_d     = hold_q;
    mute_app_d = mute_app_q;
    swap_d     = swap_q;
    byp_d      = byp_q;
    case (state_q)
      ST_IDLE: begin
        if (struct_chg) begin
          state_d = ST_FADE_OUT;
        end else if (mute_i != mute_app_q) begin
          mute_app_d = mute_i;
          state_d    = ST_SLEW;
        end else if (gain_q != tgt) begin
          state_d = ST_SLEW;
        end
      end
      ST_SLEW: begin
        if (struct_chg) begin
          state_d = ST_FADE_OUT;
        end else if (mute_i != mute_app_q) begin
          mute_app_d = mute_i;
        end else if (gain_q == tgt) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          gain_d = toward;
        end
      end
      ST_FADE_OUT: begin
        if (gain_q == '0) begin
          hold_d  = 8'(HOLD_SAMPLES);
          state_d = ST_HOLD;
        end else if (tick) begin
          gain_d = fade;
        end
      end
      ST_HOLD: begin
        gain_d = '0;
        if (hold_q == '0)
          state_d = ST_APPLY;
        else if (tick)
          hold_d = hold_q - 8'd1;
      end
      ST_APPLY: begin
        swap_d     = swap_lr_i;
        byp_d      = filter_bypass_i;
        mute_app_d = mute_i;
        state_d    = ST_SLEW;
      end
      default: state_d = ST_FADE_OUT;
    endcase
  end

  always_ff @(posedge MCLK_i or negedge nRst_int_w) begin
    if (!nRst_int_w) begin
      state_q    <= ST_HOLD;
      gain_q     <= '0;
      hold_q     <= '0;
      wdog_q     <= '0;
      mute_app_q <= 1'b0;
      swap_q     <= 1'b0;
      byp_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gain_q     <= gain_d;
      hold_q     <= hold_d;
      wdog_q     <= wdog_d;
      mute_app_q <= mute_app_d;
      swap_q     <= swap_d;
      byp_q      <= byp_d;
    end
  end

  assign gain_o          = gain_q;
  assign swap_lr_o       = swap_q;
  assign filter_bypass_o = byp_q;
  assign mute_o          = mute_app_q & (gain_q == '0);
  assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_apu_gain_ramp_ctrl.sv
// Scoreboard bench: every time the output snapshot {gain, swap, bypass,
// mute, busy} changes, the monitor pops the next expected snapshot and,
// where given, checks the number of cycles since the previous change.
module tb_apu_gain_ramp_ctrl;
  localparam int TICK_PER = 128;
  localparam int HOLD     = 48;
  localparam int TMO      = 1024;

  logic       MCLK_i = 1'b0;
  logic       nRst_int_w = 1'b1;
  logic       sample_tick_i = 1'b0;
  logic [4:0] level_i = 5'd19;
  logic       mute_i = 1'b0, swap_lr_i = 1'b0, filter_bypass_i = 1'b0;
  logic [8:0] gain_o;
  logic       swap_lr_o, filter_bypass_o, mute_o, busy_o;

  apu_gain_ramp_ctrl #(.STEP(1), .HOLD_SAMPLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .MCLK_i(MCLK_i), .nRst_int_w(nRst_int_w), .sample_tick_i(sample_tick_i),
    .level_i(level_i), .mute_i(mute_i), .swap_lr_i(swap_lr_i),
    .filter_bypass_i(filter_bypass_i), .gain_o(gain_o), .swap_lr_o(swap_lr_o),
    .filter_bypass_o(filter_bypass_o), .mute_o(mute_o), .busy_o(busy_o));

  always #5 MCLK_i = ~MCLK_i;

  typedef struct packed {
    logic [8:0] g;
    logic sw, by, mu, bu;
  } snap_t;

  typedef struct {
    snap_t s;
    int    dt;   // expected cycles since previous change, 0 = don't care
    string tag;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0, checks = 0;
  int    cyc = 0, last_cyc = 0;
  snap_t last = '0;
  bit    tick_en = 1'b0;
  int    tcnt = 0;

  // Sample strobe generator: one pulse every TICK_PER cycles while enabled.
  initial forever begin
    @(posedge MCLK_i); #1;
    if (tick_en) begin
      tcnt++;
      if (tcnt >= TICK_PER) begin sample_tick_i = 1'b1; tcnt = 0; end
      else sample_tick_i = 1'b0;
    end else sample_tick_i = 1'b0;
  end

  // Monitor
  always @(negedge MCLK_i) begin
    snap_t cur;
    exp_t  e;
    int    dt;
    cyc++;
    cur = {gain_o, swap_lr_o, filter_bypass_o, mute_o, busy_o};
    if (cur !== last) begin
      dt = cyc - last_cyc;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got g=%0d sw=%0d by=%0d mu=%0d bu=%0d, expected no change",
                 cur.g, cur.sw, cur.by, cur.mu, cur.bu);
      end else begin
        e = sb.pop_front();
        if (cur !== e.s) begin
          errors++;
          $display("FAIL %s: got g=%0d sw=%0d by=%0d mu=%0d bu=%0d, expected g=%0d sw=%0d by=%0d mu=%0d bu=%0d",
                   e.tag, cur.g, cur.sw, cur.by, cur.mu, cur.bu, e.s.g, e.s.sw, e.s.by, e.s.mu, e.s.bu);
        end
        if (e.dt != 0) begin
          checks++;
          if (dt != e.dt) begin
            errors++;
            $display("FAIL %s_timing: got %0d cycles since last change, expected %0d", e.tag, dt, e.dt);
          end
        end
      end
      last = cur;
      last_cyc = cyc;
    end
  end

  task automatic push(string tag, int g, bit sw, bit by, bit mu, bit bu, int dt);
    exp_t e;
    e.s = {9'(g), sw, by, mu, bu};
    e.dt = dt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Gain ramp from..to inclusive, busy high; first entry gets first_dt.
  task automatic ramp(string tag, int from, int to, bit sw, bit by, bit mu, int first_dt);
    int g = from;
    int st = (to >= from) ? 1 : -1;
    push(tag, g, sw, by, mu, 1'b1, first_dt);
    while (g != to) begin
      g += st;
      push(tag, g, sw, by, mu, 1'b1, TICK_PER);
    end
  endtask

  task automatic drain(string tag, int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin @(negedge MCLK_i); n++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d expected changes still pending, required 0", tag, sb.size());
      sb.delete();
    end
    repeat (8) @(negedge MCLK_i);
  endtask

  task automatic drive_at_edge();
    @(posedge MCLK_i); #1;
  endtask

  initial begin
    int n;
    // Reset state
    push("reset", 0, 0, 0, 0, 1, 0);
    #1 nRst_int_w = 1'b0;
    repeat (4) @(negedge MCLK_i);

    // Soft start 0 -> 32 at level 19
    ramp("softstart", 1, 32, 0, 0, 0, 0);
    push("softstart_idle", 32, 0, 0, 0, 0, 1);
    #2 nRst_int_w = 1'b1;
    tick_en = 1'b1;
    drain("softstart", 40 * TICK_PER);

    // Level change only slews; routing untouched
    drive_at_edge(); level_i = 5'd25;
    push("lvl_up_busy", 32, 0, 0, 0, 1, 0);
    ramp("lvl_up", 33, 64, 0, 0, 0, 0);
    push("lvl_up_idle", 64, 0, 0, 0, 0, 1);
    drain("lvl_up", 40 * TICK_PER);
    drive_at_edge(); level_i = 5'd19;
    push("lvl_dn_busy", 64, 0, 0, 0, 1, 0);
    ramp("lvl_dn", 63, 32, 0, 0, 0, 0);
    push("lvl_dn_idle", 32, 0, 0, 0, 0, 1);
    drain("lvl_dn", 40 * TICK_PER);

    // Swap: fade out, hold HOLD ticks, apply, fade in.
    // Gain hits 0 at tick edge E; FADE_OUT->HOLD at E+1; last hold tick at
    // E+HOLD*T; APPLY entered E+HOLD*T+1; swap visible E+HOLD*T+2.
    drive_at_edge(); swap_lr_i = 1'b1;
    push("swap_busy", 32, 0, 0, 0, 1, 0);
    ramp("swap_fade", 31, 0, 0, 0, 0, 0);
    push("swap_apply", 0, 1, 0, 0, 1, HOLD * TICK_PER + 2);
    push("swap_in", 1, 1, 0, 0, 1, TICK_PER - 2);
    ramp("swap_in", 2, 32, 1, 0, 0, TICK_PER);
    push("swap_idle", 32, 1, 0, 0, 0, 1);
    drain("swap", 120 * TICK_PER);

    // Mute ramps to 0; mute_o only once gain is 0
    drive_at_edge(); mute_i = 1'b1;
    push("mute_busy", 32, 1, 0, 0, 1, 0);
    ramp("mute_fade", 31, 1, 1, 0, 0, 0);
    push("mute_zero", 0, 1, 0, 1, 1, TICK_PER);
    push("mute_idle", 0, 1, 0, 1, 0, 1);
    drain("mute", 40 * TICK_PER);
    drive_at_edge(); mute_i = 1'b0;
    push("unmute_busy", 0, 1, 0, 0, 1, 0);
    ramp("unmute", 1, 32, 1, 0, 0, 0);
    push("unmute_idle", 32, 1, 0, 0, 0, 1);
    drain("unmute", 40 * TICK_PER);

    // No sample strobes: watchdog paces the ramp
    tick_en = 1'b0;
    repeat (4) @(negedge MCLK_i);
    drive_at_edge(); level_i = 5'd20;
    push("wdog_busy", 32, 1, 0, 0, 1, 0);
    push("wdog", 33, 1, 0, 0, 1, 0);
    push("wdog", 34, 1, 0, 0, 1, TMO);
    push("wdog", 35, 1, 0, 0, 1, TMO);
    push("wdog", 36, 1, 0, 0, 1, TMO);
    push("wdog_idle", 36, 1, 0, 0, 0, 1);
    drain("wdog", 6 * TMO);

    // Reset during FADE_OUT at gain 17, then restart with new config
    tick_en = 1'b1;
    drive_at_edge(); filter_bypass_i = 1'b1;
    push("byp_busy", 36, 1, 0, 0, 1, 0);
    ramp("byp_fade", 35, 17, 1, 0, 0, 0);
    n = 0;
    while (gain_o != 9'd17 && n < 30 * TICK_PER) begin @(negedge MCLK_i); n++; end
    if (gain_o != 9'd17) begin
      checks++; errors++;
      $display("FAIL fade_to_17_timeout: got gain %0d, required 17", gain_o);
    end
    #2;
    level_i = 5'd19;
    push("midreset", 0, 0, 0, 0, 1, 0);
    nRst_int_w = 1'b0;
    repeat (3) @(negedge MCLK_i);
    push("rst_apply", 0, 1, 1, 0, 1, 0);
    ramp("rst_softstart", 1, 32, 1, 1, 0, 0);
    push("rst_idle", 32, 1, 1, 0, 0, 1);
    #2 nRst_int_w = 1'b1;
    drain("rst_softstart", 40 * TICK_PER);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
